// File: rtl/proc_pkg.sv
// Shared definitions for the 8-register processor control path: opcodes,
// timestep encoding and instruction-register field positions.
package proc_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // IR layout is IIIXXXYYY
    localparam int IR_W     = 9;
    localparam int IR_OP_HI = 8;
    localparam int IR_OP_LO = 6;
    localparam int IR_X_HI  = 5;
    localparam int IR_X_LO  = 3;
    localparam int IR_Y_HI  = 2;
    localparam int IR_Y_LO  = 0;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; shared with the register file.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] w,
    output logic [7:0] y
);

    always_comb begin
        y = 8'b0;
        if (en) begin
            y[w] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle control FSM: captures IIIXXXYYY from DIN into IR and sequences
// bus selects, register enables and ALU strobes over timesteps T0..T3.
module proc_control_unit
    import proc_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Run,
    input  logic [N-1:0] DIN,
    output logic [7:0]   sel_r,
    output logic         sel_g,
    output logic         sel_din,
    output logic [7:0]   r_in,
    output logic         a_in,
    output logic         g_in,
    output logic         add_sub,
    output logic         ir_in,
    output logic         done
);

    state_e            state_q, state_d;
    logic [IR_W-1:0]   ir_q;
    logic [2:0]        opcode, rx, ry;
    logic [2:0]        sel_idx;
    logic              wr_en;

    // Only the instruction field of DIN is consumed; immediates go straight to the bus mux.
    logic unused_din;
    assign unused_din = ^DIN[N-IR_W-1:0];

    assign opcode = ir_q[IR_OP_HI:IR_OP_LO];
    assign rx     = ir_q[IR_X_HI:IR_X_LO];
    assign ry     = ir_q[IR_Y_HI:IR_Y_LO];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == T0 && Run) begin
                ir_q <= DIN[N-1:N-IR_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_idx = 3'd0;
        sel_g   = 1'b0;
        sel_din = 1'b0;
        wr_en   = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        add_sub = 1'b0;
        ir_in   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            T0: begin
                // Gated by Resetn so nothing toggles while reset is held.
                ir_in = Run & Resetn;
                if (Run) begin
                    state_d = T1;
                end
            end
            T1: begin
                state_d = T0;
                unique case (opcode)
                    OP_MV: begin
                        sel_idx = ry;
                        wr_en   = 1'b1;
                        done    = 1'b1;
                    end
                    OP_MVI: begin
                        sel_din = 1'b1;
                        wr_en   = 1'b1;
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        sel_idx = rx;
                        a_in    = 1'b1;
                        state_d = T2;
                    end
                    default: begin
                        done = 1'b1;
                    end
                endcase
            end
            T2: begin
                sel_idx = ry;
                g_in    = 1'b1;
                add_sub = (opcode == OP_SUB);
                state_d = T3;
            end
            T3: begin
                sel_g   = 1'b1;
                wr_en   = 1'b1;
                done    = 1'b1;
                state_d = T0;
            end
            default: begin
                state_d = T0;
            end
        endcase
    end

    assign sel_r = {5'b0, sel_idx};

    dec3to8 u_dec_rin (
        .en (wr_en),
        .w  (rx),
        .y  (r_in)
    );

endmodule

// File: tb/tb_proc_control_unit.sv
// Scoreboard bench for proc_control_unit: stimulus pushes expected per-cycle
// output bundles, a negedge monitor pops and compares them.
module tb_proc_control_unit;
    import proc_pkg::*;

    localparam int N = 16;

    logic         Clock;
    logic         Resetn;
    logic         Run;
    logic [N-1:0] DIN;
    logic [7:0]   sel_r;
    logic         sel_g;
    logic         sel_din;
    logic [7:0]   r_in;
    logic         a_in;
    logic         g_in;
    logic         add_sub;
    logic         ir_in;
    logic         done;

    proc_control_unit #(.N(N)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Run     (Run),
        .DIN     (DIN),
        .sel_r   (sel_r),
        .sel_g   (sel_g),
        .sel_din (sel_din),
        .r_in    (r_in),
        .a_in    (a_in),
        .g_in    (g_in),
        .add_sub (add_sub),
        .ir_in   (ir_in),
        .done    (done)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    logic [22:0] obs;
    assign obs = {sel_r, sel_g, sel_din, r_in, a_in, g_in, add_sub, ir_in, done};

    // Queue entry: {expected latency (done cycles only), expected output bundle}
    logic [30:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    function automatic logic [30:0] mk(input logic [7:0] sr, input logic g, input logic din,
                                       input logic [7:0] rin, input logic a, input logic gi,
                                       input logic as, input logic ir, input logic dn,
                                       input logic [7:0] lat);
        return {lat, sr, g, din, rin, a, gi, as, ir, dn};
    endfunction

    function automatic logic [N-1:0] instr(input logic [2:0] op, input logic [2:0] x,
                                           input logic [2:0] y);
        return {op, x, y, 7'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    // Monitor
    int cyc_n      = 0;
    int last_ir    = 0;
    logic prev_done = 1'b0;

    always @(negedge Clock) begin
        if (Resetn) begin
            logic [30:0] e;
            cyc_n++;
            if (obs != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {9'b0, obs}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("bundle", {9'b0, obs}, {9'b0, e[22:0]});
                    if (done) begin
                        check("latency", cyc_n - last_ir, {24'b0, e[30:23]});
                    end
                end
            end
            if (done) begin
                check("done_consecutive", {31'b0, prev_done}, 32'h0);
            end
            if (ir_in) begin
                last_ir = cyc_n;
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        Resetn = 1'b0;
        Run    = 1'b1;
        DIN    = instr(OP_ADD, 3'd1, 3'd2);
        #12;
        check("reset_outputs_zero", {9'b0, obs}, 32'h0);
        cyc();
        Run = 1'b0;
        DIN = '0;
        #2;
        Resetn = 1'b1;
        cyc();
        check("post_reset_state", {30'b0, dut.state_q}, {30'b0, T0});
        check("post_reset_ir", {23'b0, dut.ir_q}, 32'h0);

        // mv R3,R5
        Run = 1'b1; DIN = instr(OP_MV, 3'd3, 3'd5);
        exp_q.push_back(mk(8'd0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'd0));
        cyc();
        Run = 1'b0; DIN = '0;
        exp_q.push_back(mk(8'd5, 0, 0, 8'b0000_1000, 0, 0, 0, 0, 1, 8'd1));
        cyc();
        cyc();
        check("idle_after_mv", {9'b0, obs}, 32'h0);

        // mvi R1,#0x1234
        Run = 1'b1; DIN = instr(OP_MVI, 3'd1, 3'd0);
        exp_q.push_back(mk(8'd0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'd0));
        cyc();
        Run = 1'b0; DIN = 16'h1234;
        exp_q.push_back(mk(8'd0, 0, 1, 8'b0000_0010, 0, 0, 0, 0, 1, 8'd1));
        cyc();
        DIN = '0;

        // add R0,R7
        Run = 1'b1; DIN = instr(OP_ADD, 3'd0, 3'd7);
        exp_q.push_back(mk(8'd0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'd0));
        cyc();
        Run = 1'b0; DIN = '0;
        exp_q.push_back(mk(8'd0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'd0));
        cyc();
        exp_q.push_back(mk(8'd7, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'd0));
        cyc();
        exp_q.push_back(mk(8'd0, 1, 0, 8'b0000_0001, 0, 0, 0, 0, 1, 8'd3));
        cyc();
        cyc();

        // sub R4,R4 then mv R6,R4 with Run held high
        Run = 1'b1; DIN = instr(OP_SUB, 3'd4, 3'd4);
        exp_q.push_back(mk(8'd0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'd0));
        cyc();
        DIN = instr(OP_MV, 3'd6, 3'd4);
        exp_q.push_back(mk(8'd4, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'd0));
        cyc();
        exp_q.push_back(mk(8'd4, 0, 0, 8'h00, 0, 1, 1, 0, 0, 8'd0));
        cyc();
        exp_q.push_back(mk(8'd0, 1, 0, 8'b0001_0000, 0, 0, 0, 0, 1, 8'd3));
        cyc();
        exp_q.push_back(mk(8'd0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'd0));
        cyc();
        Run = 1'b0; DIN = '0;
        exp_q.push_back(mk(8'd4, 0, 0, 8'b0100_0000, 0, 0, 0, 0, 1, 8'd1));
        cyc();
        cyc();

        // reserved opcode 111
        Run = 1'b1; DIN = instr(3'b111, 3'd2, 3'd3);
        exp_q.push_back(mk(8'd0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'd0));
        cyc();
        Run = 1'b0; DIN = '0;
        exp_q.push_back(mk(8'd0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'd1));
        cyc();

        // add R5,R2 with Run toggling during T1..T3
        Run = 1'b1; DIN = instr(OP_ADD, 3'd5, 3'd2);
        exp_q.push_back(mk(8'd0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'd0));
        cyc();
        Run = 1'b0; DIN = instr(OP_MV, 3'd1, 3'd1);
        exp_q.push_back(mk(8'd5, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'd0));
        cyc();
        Run = 1'b1;
        exp_q.push_back(mk(8'd2, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'd0));
        cyc();
        Run = 1'b0;
        exp_q.push_back(mk(8'd0, 1, 0, 8'b0010_0000, 0, 0, 0, 0, 1, 8'd3));
        cyc();
        DIN = '0;
        cyc();

        // add R1,R6 interrupted by reset during T2
        Run = 1'b1; DIN = instr(OP_ADD, 3'd1, 3'd6);
        exp_q.push_back(mk(8'd0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'd0));
        cyc();
        Run = 1'b0; DIN = '0;
        exp_q.push_back(mk(8'd1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'd0));
        cyc();
        #1;
        Resetn = 1'b0;
        Run    = 1'b1;
        #1;
        check("mid_reset_outputs_zero", {9'b0, obs}, 32'h0);
        cyc();
        check("held_reset_outputs_zero", {9'b0, obs}, 32'h0);
        Run = 1'b0;
        #2;
        Resetn = 1'b1;
        cyc();
        check("after_reset_state", {30'b0, dut.state_q}, {30'b0, T0});
        check("after_reset_ir", {23'b0, dut.ir_q}, 32'h0);
        check("after_reset_idle", {9'b0, obs}, 32'h0);
        repeat (3) cyc();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            cyc();
        end
        check("scoreboard_drained", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
